mem_access_bridge: RTL

- Responder for the M-stage memory controls the pipeline controller issues (memenM, memwriteM, alucontrolM).
- Turns each load/store into one transaction on the two-phase (addr_ok/data_ok) data bus.
- Aligns and extends load data, generates byte strobes, flags misaligned accesses, and raises a stall request to the hazard unit until the access completes.
- Sits between the M-stage datapath and the data-side bus arbiter.

---
 rtl/mem_access_bridge_pkg.sv | 28 ++
 rtl/mem_align_unit.sv | 64 ++++++
 rtl/mem_access_bridge.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_bridge_pkg.sv
// Shared opcode, bus-size and FSM-state definitions for the M-stage memory bridge.
package mem_access_bridge_pkg;

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ADDR = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    function automatic logic is_signed_load(input logic [7:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

endpackage

// File: rtl/mem_align_unit.sv
// Combinational lane logic: decodes opcode into bus size, builds store lanes/strobes,
// detects misalignment and aligns/extends returned load data.
module mem_align_unit
    import mem_access_bridge_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]        i_addr_lo,
    input  logic [7:0]        i_op,
    input  logic [DW-1:0]     i_wdata,
    input  logic [DW-1:0]     i_rdata,
    output logic              o_valid,
    output logic [1:0]        o_size,
    output logic [DW/8-1:0]   o_wstrb,
    output logic [DW-1:0]     o_wdata,
    output logic              o_misalign,
    output logic [DW-1:0]     o_rdata
);
    localparam int LANES = DW / 8;

    logic        w_signed;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_valid  = 1'b1;
        o_size   = SIZE_WORD;
        case (i_op)
            OP_LB, OP_LBU, OP_SB: o_size = SIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: o_size = SIZE_HALF;
            OP_LW, OP_SW:         o_size = SIZE_WORD;
            default:              o_valid = 1'b0;
        endcase
    end

    assign w_signed   = is_signed_load(i_op);
    assign o_misalign = o_valid &&
                        (((o_size == SIZE_HALF) && i_addr_lo[0]) ||
                         ((o_size == SIZE_WORD) && (i_addr_lo != 2'b00)));

    // Each lane gets the byte/half replicated so the slave can pick any lane by strobe.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign o_wdata[8*gi +: 8] = (o_size == SIZE_BYTE) ? i_wdata[7:0] :
                                    (o_size == SIZE_HALF) ? i_wdata[8*(gi%2) +: 8] :
                                                            i_wdata[8*gi +: 8];
        assign o_wstrb[gi]        = (o_size == SIZE_BYTE) ? (i_addr_lo == LANE) :
                                    (o_size == SIZE_HALF) ? (i_addr_lo[1] == LANE[1]) :
                                                            1'b1;
    end

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_rdata = i_rdata;
        if (o_size == SIZE_BYTE) begin
            o_rdata = {{(DW-8){w_signed & w_byte[7]}}, w_byte};
        end else if (o_size == SIZE_HALF) begin
            o_rdata = {{(DW-16){w_signed & w_half[15]}}, w_half};
        end
    end

endmodule

// File: rtl/mem_access_bridge.sv
// M-stage load/store responder: issues one addr_ok/data_ok bus transaction per access
// and holds the pipeline via stall_reqM until the access has completed.
module mem_access_bridge
    import mem_access_bridge_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          memenM,
    input  logic          memwriteM,
    input  logic [7:0]    alucontrolM,
    input  logic [AW-1:0] addrM,
    input  logic [DW-1:0] writedataM,
    input  logic          flushM,
    input  logic          pipe_stallM,
    output logic [DW-1:0] readdataM,
    output logic          stall_reqM,
    output logic          adelM,
    output logic          adesM,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [AW-1:0] data_addr,
    output logic [DW-1:0] data_wdata,
    output logic [3:0]    data_wstrb,
    input  logic          data_addr_ok,
    input  logic [DW-1:0] data_rdata,
    input  logic          data_data_ok
);
    state_t          r_state;
    state_t          w_state_next;
    logic            r_cancel;
    logic [AW-1:0]   r_addr;
    logic [7:0]      r_op;
    logic [DW-1:0]   r_wdata;
    logic            r_wr;
    logic [DW-1:0]   r_readdata;

    logic            w_live_valid;
    logic            w_live_misalign;
    logic [1:0]      w_live_size;
    logic [3:0]      w_live_wstrb;
    logic [DW-1:0]   w_live_wdata;
    logic [DW-1:0]   w_live_rdata;
    logic            w_cap_valid;
    logic            w_cap_misalign;
    logic [1:0]      w_cap_size;
    logic [3:0]      w_cap_wstrb;
    logic [DW-1:0]   w_cap_wdata;
    logic [DW-1:0]   w_cap_rdata;
    logic            w_unused_ok;

    logic            w_run;
    logic            w_issue;
    logic            w_cancel_eff;
    logic            w_req;
    logic            w_stall;
    logic            w_use_cap;
    logic            w_bus_wr;
    logic [1:0]      w_bus_size;
    logic [AW-1:0]   w_bus_addr;

    // Live decode serves the IDLE issue and the state-independent error flags.
    mem_align_unit #(.DW(DW)) u_align_live (
        .i_addr_lo  (addrM[1:0]),
        .i_op       (alucontrolM),
        .i_wdata    (writedataM),
        .i_rdata    (data_rdata),
        .o_valid    (w_live_valid),
        .o_size     (w_live_size),
        .o_wstrb    (w_live_wstrb),
        .o_wdata    (w_live_wdata),
        .o_misalign (w_live_misalign),
        .o_rdata    (w_live_rdata)
    );

    // Captured decode keeps the bus fields stable and aligns the returned data.
    mem_align_unit #(.DW(DW)) u_align_cap (
        .i_addr_lo  (r_addr[1:0]),
        .i_op       (r_op),
        .i_wdata    (r_wdata),
        .i_rdata    (data_rdata),
        .o_valid    (w_cap_valid),
        .o_size     (w_cap_size),
        .o_wstrb    (w_cap_wstrb),
        .o_wdata    (w_cap_wdata),
        .o_misalign (w_cap_misalign),
        .o_rdata    (w_cap_rdata)
    );

    assign w_unused_ok  = ^{w_live_rdata, w_cap_valid, w_cap_misalign};

    assign w_run        = ~rst;
    assign w_issue      = memenM & w_live_valid & ~w_live_misalign & ~flushM;
    assign w_cancel_eff = r_cancel | flushM;

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_stall      = 1'b0;
        w_use_cap    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_req        = 1'b1;
                    w_stall      = 1'b1;
                    w_state_next = data_addr_ok ? ST_WAIT_DATA : ST_WAIT_ADDR;
                end
            end
            ST_WAIT_ADDR: begin
                w_req     = 1'b1;
                w_stall   = 1'b1;
                w_use_cap = 1'b1;
                if (data_addr_ok) begin
                    w_state_next = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                w_stall   = 1'b1;
                w_use_cap = 1'b1;
                if (data_data_ok) begin
                    w_state_next = w_cancel_eff ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: begin
                // Stay here while held so the still-present M-stage access is not re-issued.
                if (!pipe_stallM) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_bus_wr   = w_use_cap ? r_wr : memwriteM;
    assign w_bus_size = w_use_cap ? w_cap_size : w_live_size;
    assign w_bus_addr = w_use_cap ? r_addr : addrM;

    assign data_req   = w_run & w_req;
    assign stall_reqM = w_run & w_stall;
    assign data_wr    = w_run & w_bus_wr;
    assign data_size  = w_run ? w_bus_size : 2'b00;
    assign data_addr  = !w_run ? '0 :
                        (w_bus_size == SIZE_WORD) ? {w_bus_addr[AW-1:2], 2'b00} : w_bus_addr;
    assign data_wdata = !w_run ? '0 : (w_use_cap ? w_cap_wdata : w_live_wdata);
    assign data_wstrb = !w_run ? 4'b0000 :
                        ((w_use_cap ? w_cap_wstrb : w_live_wstrb) & {4{w_bus_wr}});
    assign adelM      = w_run & memenM & w_live_misalign & ~memwriteM;
    assign adesM      = w_run & memenM & w_live_misalign & memwriteM;
    assign readdataM  = r_readdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cancel   <= 1'b0;
            r_addr     <= '0;
            r_op       <= '0;
            r_wdata    <= '0;
            r_wr       <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == ST_IDLE) && w_issue) begin
                r_addr  <= addrM;
                r_op    <= alucontrolM;
                r_wdata <= writedataM;
                r_wr    <= memwriteM;
            end
            if (w_state_next == ST_IDLE) begin
                r_cancel <= 1'b0;
            end else if (((r_state == ST_WAIT_ADDR) || (r_state == ST_WAIT_DATA)) && flushM) begin
                r_cancel <= 1'b1;
            end
            if ((r_state == ST_WAIT_DATA) && data_data_ok && !w_cancel_eff && !r_wr) begin
                r_readdata <= w_cap_rdata;
            end
        end
    end

endmodule
